// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM state type and small op-class helpers.
package muldiv_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_WRITE
  } state_t;

  // MULT/MULTU/DIV/DIVU all have a zero top bit.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return ~op[2] & op[1];
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return ~op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for one shift-add multiply or restoring divide step per cycle.
// acc holds the product, or {remainder, quotient} while dividing.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic                step,
  input  logic                div_mode,
  input  logic [SIZE-1:0]     a_mag,
  input  logic [SIZE-1:0]     b_mag,
  output logic [2*SIZE-1:0]   acc,
  output logic                mplier_last
);

  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [2*SIZE-1:0] mcand_q, mcand_d;
  logic [SIZE-1:0]   mplier_q, mplier_d;
  logic [SIZE:0]     rem_sh;
  logic [SIZE:0]     diff;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    // Partial remainder shifted left with the next dividend bit brought in.
    rem_sh   = acc_q[2*SIZE-1:SIZE-1];
    diff     = rem_sh - {1'b0, mcand_q[SIZE-1:0]};
    if (load) begin
      acc_d    = div_mode ? {{SIZE{1'b0}}, a_mag} : '0;
      mcand_d  = div_mode ? {{SIZE{1'b0}}, b_mag} : {{SIZE{1'b0}}, a_mag};
      mplier_d = b_mag;
    end else if (step) begin
      if (div_mode) begin
        if (!diff[SIZE]) begin
          acc_d = {diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[SIZE-1:0], acc_q[SIZE-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc         = acc_q;
  // True when the multiplier will be zero after the step taken this cycle.
  assign mplier_last = (mplier_q[SIZE-1:1] == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the multicycle MIPS core.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the multiplier runs out of ones.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [SIZE-1:0] SrcA,
  input  logic [SIZE-1:0] SrcB,
  input  logic            ReadReq,
  output logic            Busy,
  output logic            Stall,
  output logic            Done,
  output logic            DivZero,
  output logic            HLEN,
  output logic            HEN,
  output logic            LEN,
  output logic [SIZE-1:0] ALUResult_1,
  output logic [SIZE-1:0] ALUResult_2
);

  localparam int CNT_W = $clog2(SIZE) + 1;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   res1_q, res1_d;
  logic [SIZE-1:0]   res2_q, res2_d;

  logic              op_signed;
  logic              op_div;
  logic [SIZE-1:0]   a_mag;
  logic [SIZE-1:0]   b_mag;
  logic [2*SIZE-1:0] acc;
  logic              mplier_last;
  logic              iter_last;
  logic [2*SIZE-1:0] prod;
  logic [SIZE-1:0]   quot;
  logic [SIZE-1:0]   rem;

  assign op_signed = is_signed_op(op_q);
  assign op_div    = is_div_op(op_q);
  assign a_mag     = (op_signed && a_q[SIZE-1]) ? -a_q : a_q;
  assign b_mag     = (op_signed && b_q[SIZE-1]) ? -b_q : b_q;

  muldiv_iter #(.SIZE(SIZE)) u_iter (
    .CLK         (CLK),
    .RST         (RST),
    .load        (state_q == ST_PREP),
    .step        (state_q == ST_ITER),
    .div_mode    (op_div),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .acc         (acc),
    .mplier_last (mplier_last)
  );

`ifdef MULDIV_EARLY_TERM_EN
  assign iter_last = (cnt_q == CNT_W'(SIZE - 1)) || (!op_div && mplier_last);
`else
  assign iter_last = (cnt_q == CNT_W'(SIZE - 1));
`endif

  assign prod = neg_res_q ? -acc : acc;
  assign quot = neg_res_q ? -acc[SIZE-1:0] : acc[SIZE-1:0];
  assign rem  = neg_rem_q ? -acc[2*SIZE-1:SIZE] : acc[2*SIZE-1:SIZE];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_muldiv(Op)) begin
            op_d    = Op;
            a_d     = SrcA;
            b_d     = SrcB;
            dz_d    = 1'b0;
            state_d = ST_PREP;
          end else if (Op == OP_MTHI || Op == OP_MTLO) begin
            op_d    = Op;
            res1_d  = SrcA;
            dz_d    = 1'b0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_PREP: begin
        neg_res_d = op_signed & (a_q[SIZE-1] ^ b_q[SIZE-1]);
        neg_rem_d = op_signed & a_q[SIZE-1];
        cnt_d     = '0;
        if (op_div && b_q == '0) begin
          dz_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (iter_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (op_div) begin
          res1_d = rem;
          res2_d = quot;
        end else begin
          res1_d = prod[2*SIZE-1:SIZE];
          res2_d = prod[SIZE-1:0];
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
    end
  end

  // Write strobes come straight from the WRITE state so at most one is ever high.
  assign Busy        = (state_q != ST_IDLE);
  assign Stall       = ReadReq & Busy;
  assign Done        = (state_q == ST_WRITE);
  assign DivZero     = Done & dz_q;
  assign HLEN        = Done & is_muldiv(op_q) & ~dz_q;
  assign HEN         = Done & (op_q == OP_MTHI);
  assign LEN         = Done & (op_q == OP_MTLO);
  assign ALUResult_1 = res1_q;
  assign ALUResult_2 = res2_q;

endmodule
